data_mem: RTL and testbench
===========================

Name: data_mem

Overview:
- Word-organised data memory for the single-cycle MIPS CPU; serves load/store accesses from the datapath.
- Read is combinational (asynchronous), so a load completes in the same cycle.
- Write is synchronous on the rising clock edge, gated by the write enable.
- Byte address in; word-aligned index derived from address bits [31:2].

Parameters:
- DATA_W, 32, data word width in bits (fixed at 32 for MIPS).
- DEPTH, 64, number of words stored; must be a power of two.

Ports:
- clk  input  1  system clock; all writes occur on its rising edge.
- rst_n  input  1  asynchronous active-low reset; one clock, reset asynchronous and active-low.
- we  input  1  write enable; active high.
- a  input  32  byte address from the ALU.
- wd  input  32  write data (rt register value).
- rd  output  32  read data at the word addressed by a.

Behaviour:
- Storage: DEPTH words of DATA_W bits.
- Index:
  - word index = a[log2(DEPTH)+1 : 2].
  - a[1:0] ignored; no misalignment fault. For example, a=12 and a=14 both select word 3.
  - Upper bits a[31 : log2(DEPTH)+2] ignored, so addresses wrap modulo 4*DEPTH bytes.
- Read:
  - rd = mem[index], purely combinational; zero-cycle latency.
  - rd updates immediately on any change of a or of the addressed word's contents.
- Write:
  - On rising clk with rst_n=1 and we=1: mem[index] <= wd.
  - we=0: memory unchanged.
  - New value visible on rd immediately after the edge. No write-through before the edge: in a same-cycle read/write of one word, rd shows the old value until the edge.
- Reset:
  - rst_n=0 asynchronously clears every word to 32'h0, independent of clk. rd therefore reads 0 at every address during and after reset.
  - Writes are suppressed while rst_n=0.
  - Reset asserted mid-operation discards all stored data.
  - Deassertion is taken synchronously by the design around it. The first write is accepted on the first rising edge with rst_n=1.
- No X propagation from storage after reset. Before the first reset, contents are undefined.
- No handshake and no busy state. Every cycle accepts at most one write.

Test Plan:
1. Reset: hold rst_n=0 with we=1, a=8, wd=32'hDEADBEEF across two edges; release. Required: rd=32'h0 at a=0,4,8,252.
2. Write/read: write 32'hf0f0f0f0 at a=16, then 32'h01010101 at a=12, we=0. Required: rd=32'h01010101 at a=12 and rd=32'hf0f0f0f0 at a=16.
3. Alignment aliasing: write 32'hf0f0f0f0 at a=14, then 32'h01010101 at a=12. Required: reading a=14 or a=12 gives 32'h01010101.
4. Write-enable gating and read timing:
   - With we=0, present wd=32'h12345678 at a=20 for several edges. Required: rd at a=20 unchanged.
   - Then set we=1. Required: before the edge rd shows the old value; after the edge rd=32'h12345678.
5. Wrap-around: write 32'hA5A5A5A5 at a=256 (DEPTH=64). Required: rd=32'hA5A5A5A5 at a=0.
6. Mid-operation reset: after scenario 2, pulse rst_n low between clock edges. Required: rd drops to 32'h0 without waiting for clk, and all previously written words read 0.

Source files
------------

// File: rtl/data_mem.sv
// data_mem: word-organised MIPS data memory, async read, sync write, async clear
module data_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [31:0]       a,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     idx;
  assign idx = a[AW+1:2];
  assign rd  = mem[idx];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[idx] <= wd;
    end
  end
endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: directed self-checking bench for data_mem
module tb_data_mem;
  logic        clk = 0;
  logic        rst_n = 1;
  logic        we = 0;
  logic [31:0] a = 0;
  logic [31:0] wd = 0;
  logic [31:0] rd;
  int checks = 0;
  int failures = 0;
  data_mem dut (.clk(clk), .rst_n(rst_n), .we(we), .a(a), .wd(wd), .rd(rd));
  always #5 clk = ~clk;
  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    we = 1;
    a = addr;
    wd = data;
    @(negedge clk);
    we = 0;
  endtask
  task automatic test_reset;
    logic [31:0] addrs [4] = '{32'd0, 32'd4, 32'd8, 32'd252};
    #2 rst_n = 0;
    we = 1;
    a = 8;
    wd = 32'hDEADBEEF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    we = 0;
    for (int i = 0; i < 4; i++) begin
      a = addrs[i];
      #1 checks++;
      if (rd !== 32'h0) begin
        failures++;
        $display("FAIL reset a=%0d rd=%h exp=%h", addrs[i], rd, 32'h0);
      end
    end
  endtask
  task automatic test_write_read;
    wr(16, 32'hf0f0f0f0);
    wr(12, 32'h01010101);
    a = 12;
    #1 checks++;
    if (rd !== 32'h01010101) begin
      failures++;
      $display("FAIL wr_rd a=12 rd=%h exp=%h", rd, 32'h01010101);
    end
    a = 16;
    #1 checks++;
    if (rd !== 32'hf0f0f0f0) begin
      failures++;
      $display("FAIL wr_rd a=16 rd=%h exp=%h", rd, 32'hf0f0f0f0);
    end
  endtask
  task automatic test_alias;
    wr(14, 32'hf0f0f0f0);
    wr(12, 32'h01010101);
    a = 14;
    #1 checks++;
    if (rd !== 32'h01010101) begin
      failures++;
      $display("FAIL alias a=14 rd=%h exp=%h", rd, 32'h01010101);
    end
    a = 13;
    #1 checks++;
    if (rd !== 32'h01010101) begin
      failures++;
      $display("FAIL alias a=13 rd=%h exp=%h", rd, 32'h01010101);
    end
  endtask
  task automatic test_we_gating;
    wr(20, 32'h0BADF00D);
    a = 20;
    wd = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (rd !== 32'h0BADF00D) begin
        failures++;
        $display("FAIL we_gate edge=%0d rd=%h exp=%h", i, rd, 32'h0BADF00D);
      end
    end
    we = 1;
    #1 checks++;
    if (rd !== 32'h0BADF00D) begin
      failures++;
      $display("FAIL pre_edge rd=%h exp=%h", rd, 32'h0BADF00D);
    end
    @(posedge clk);
    #1 checks++;
    if (rd !== 32'h12345678) begin
      failures++;
      $display("FAIL post_edge rd=%h exp=%h", rd, 32'h12345678);
    end
    @(negedge clk);
    we = 0;
  endtask
  task automatic test_wrap;
    wr(256, 32'hA5A5A5A5);
    a = 0;
    #1 checks++;
    if (rd !== 32'hA5A5A5A5) begin
      failures++;
      $display("FAIL wrap a=0 rd=%h exp=%h", rd, 32'hA5A5A5A5);
    end
    a = 32'hFFFF_FF00;
    #1 checks++;
    if (rd !== 32'hA5A5A5A5) begin
      failures++;
      $display("FAIL wrap a=ffffff00 rd=%h exp=%h", rd, 32'hA5A5A5A5);
    end
  endtask
  task automatic test_mid_reset;
    logic [31:0] addrs [4] = '{32'd0, 32'd12, 32'd16, 32'd20};
    wr(16, 32'hf0f0f0f0);
    wr(12, 32'h01010101);
    a = 16;
    #1 checks++;
    if (rd !== 32'hf0f0f0f0) begin
      failures++;
      $display("FAIL mid_pre rd=%h exp=%h", rd, 32'hf0f0f0f0);
    end
    #1 rst_n = 0;
    #1 checks++;
    if (rd !== 32'h0) begin
      failures++;
      $display("FAIL mid_async rd=%h exp=%h", rd, 32'h0);
    end
    for (int i = 0; i < 4; i++) begin
      a = addrs[i];
      #1 checks++;
      if (rd !== 32'h0) begin
        failures++;
        $display("FAIL mid_clear a=%0d rd=%h exp=%h", addrs[i], rd, 32'h0);
      end
    end
    @(negedge clk);
    rst_n = 1;
    wr(8, 32'h5A5A5A5A);
    a = 8;
    #1 checks++;
    if (rd !== 32'h5A5A5A5A) begin
      failures++;
      $display("FAIL post_reset_wr rd=%h exp=%h", rd, 32'h5A5A5A5A);
    end
  endtask
  initial begin
    test_reset;
    test_write_read;
    test_alias;
    test_we_gating;
    test_wrap;
    test_mid_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
